// File: rtl/round_key_add.sv
// AddRoundKey stage with on-the-fly AES-128 key expansion: XORs each accepted state with
// the current round key and advances the key schedule by one round per accept.

module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = '0;
        aa = a;
        bb = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), followed by the AES affine transform.
    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = gf_mul(x, x);
        r = p;
        for (int unsigned k = 1; k < 7; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    assign o_byte = sbox_f(i_byte);
endmodule

module round_key_add #(
    parameter int unsigned BLOCK_LENGTH = 128,
    parameter int unsigned WORD_SIZE    = 32,
    parameter int unsigned NUM_ROUNDS   = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_load,
    input  logic [BLOCK_LENGTH-1:0] cipher_key,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BLOCK_LENGTH-1:0] state_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BLOCK_LENGTH-1:0] out_state,
    output logic [3:0]              out_round,
    output logic                    out_last
);
    typedef enum logic [1:0] {S_NOKEY, S_IDLE, S_RUN} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [BLOCK_LENGTH-1:0] r_key_store;
    logic [BLOCK_LENGTH-1:0] r_rkey;
    logic [3:0]              r_round_cnt;
    logic [7:0]              r_rcon;
    logic                    r_out_valid;
    logic [BLOCK_LENGTH-1:0] r_out_state;
    logic [3:0]              r_out_round;
    logic                    r_out_last;

    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_last;
    logic                    w_key_load_ok;
    logic [WORD_SIZE-1:0]    w_w0, w_w1, w_w2, w_w3;
    logic [WORD_SIZE-1:0]    w_rot, w_sub;
    logic [WORD_SIZE-1:0]    w_n0, w_n1, w_n2, w_n3;
    logic [BLOCK_LENGTH-1:0] w_next_key;
    logic [7:0]              w_rcon_next;

    assign w_w0 = r_rkey[BLOCK_LENGTH-1 -: WORD_SIZE];
    assign w_w1 = r_rkey[BLOCK_LENGTH-1-WORD_SIZE -: WORD_SIZE];
    assign w_w2 = r_rkey[BLOCK_LENGTH-1-2*WORD_SIZE -: WORD_SIZE];
    assign w_w3 = r_rkey[WORD_SIZE-1:0];
    assign w_rot = {w_w3[WORD_SIZE-9:0], w_w3[WORD_SIZE-1 -: 8]};

    for (genvar g = 0; g < WORD_SIZE / 8; g++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (w_rot[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    assign w_n0        = w_w0 ^ w_sub ^ {r_rcon, {(WORD_SIZE-8){1'b0}}};
    assign w_n1        = w_w1 ^ w_n0;
    assign w_n2        = w_w2 ^ w_n1;
    assign w_n3        = w_w3 ^ w_n2;
    assign w_next_key  = {w_n0, w_n1, w_n2, w_n3};
    assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_NOKEY;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_in_ready    = (r_state != S_NOKEY) && !key_load && (!r_out_valid || out_ready);
        w_accept      = in_valid && w_in_ready;
        w_last        = (r_round_cnt == 4'(NUM_ROUNDS));
        w_key_load_ok = key_load && (r_state != S_RUN);
        case (r_state)
            S_NOKEY: if (key_load) w_state_next = S_IDLE;
            S_IDLE:  if (w_accept) w_state_next = w_last ? S_IDLE : S_RUN;
            S_RUN:   if (w_accept && w_last) w_state_next = S_IDLE;
            default: w_state_next = S_NOKEY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_store <= '0;
            r_rkey      <= '0;
            r_round_cnt <= '0;
            r_rcon      <= 8'h01;
            r_out_valid <= 1'b0;
            r_out_state <= '0;
            r_out_round <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_state <= state_in ^ r_rkey;
                r_out_round <= r_round_cnt;
                r_out_last  <= w_last;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            // key_load never coincides with an accept because it forces in_ready low.
            if (w_key_load_ok) begin
                r_key_store <= cipher_key;
                r_rkey      <= cipher_key;
                r_round_cnt <= '0;
                r_rcon      <= 8'h01;
            end else if (w_accept) begin
                if (w_last) begin
                    r_rkey      <= r_key_store;
                    r_round_cnt <= '0;
                    r_rcon      <= 8'h01;
                end else begin
                    r_rkey      <= w_next_key;
                    r_round_cnt <= r_round_cnt + 4'd1;
                    r_rcon      <= w_rcon_next;
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_state = r_out_state;
    assign out_round = r_out_round;
    assign out_last  = r_out_last;
endmodule

// File: tb/tb_round_key_add.sv
// Self-checking bench for round_key_add: FIPS-197 vector table, directed corner sequences,
// and randomized traffic against a full-expansion AES-128 key schedule model.

module tb_round_key_add;
    logic         clk = 1'b0;
    logic         rst, key_load, in_valid, out_ready;
    logic [127:0] cipher_key, state_in;
    logic         in_ready, out_valid, out_last;
    logic [127:0] out_state;
    logic [3:0]   out_round;

    int unsigned  n_checks = 0;
    int unsigned  n_err    = 0;

    always #5 clk = ~clk;

    round_key_add #(.BLOCK_LENGTH(128), .WORD_SIZE(32), .NUM_ROUNDS(10)) dut (
        .clk(clk), .rst(rst), .key_load(key_load), .cipher_key(cipher_key),
        .in_valid(in_valid), .in_ready(in_ready), .state_in(state_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .out_round(out_round), .out_last(out_last)
    );

    logic [7:0] SB [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };
    logic [7:0] RC [10] = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};

    // Reference model: whole-block round keys expanded up front, plus the output register.
    logic [127:0] m_rk [11];
    logic         m_have, m_ov, m_ol;
    int unsigned  m_round, m_or;
    logic [127:0] m_os;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SB[w[31:24]], SB[w[23:16]], SB[w[15:8]], SB[w[7:0]]};
    endfunction

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {RC[i/4-1], 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        logic exp_rdy;
        #1;
        exp_rdy = m_have && !key_load && (!m_ov || out_ready);
        check("in_ready", {127'b0, in_ready}, {127'b0, exp_rdy});
        @(posedge clk);
        if (rst) begin
            m_have = 1'b0; m_round = 0; m_ov = 1'b0; m_os = '0; m_or = 0; m_ol = 1'b0;
        end else begin
            if (exp_rdy && in_valid) begin
                m_os = state_in ^ m_rk[m_round];
                m_or = m_round;
                m_ol = (m_round == 10);
                m_ov = 1'b1;
                m_round = (m_round == 10) ? 0 : m_round + 1;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            if (key_load && (!m_have || m_round == 0)) begin
                expand(cipher_key);
                m_have = 1'b1;
                m_round = 0;
            end
        end
        #1;
        check("out_valid", {127'b0, out_valid}, {127'b0, m_ov});
        check("out_state", out_state, m_os);
        check("out_round", {124'b0, out_round}, {124'b0, 4'(m_or)});
        check("out_last", {127'b0, out_last}, {127'b0, m_ol});
    endtask

    task automatic step(input logic r, input logic kl, input logic [127:0] key,
                        input logic iv, input logic [127:0] st, input logic ordy);
        rst = r; key_load = kl; cipher_key = key; in_valid = iv; state_in = st; out_ready = ordy;
        cycle();
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    typedef struct {
        logic [127:0] st;
        logic [127:0] exp;
        int unsigned  rnd;
        logic         last;
        logic         chk;
    } vec_t;

    localparam logic [127:0] FKEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    initial begin
        vec_t         tbl [13];
        logic [127:0] ka, kb, kc, st;

        m_have = 1'b0; m_round = 0; m_ov = 1'b0; m_os = '0; m_or = 0; m_ol = 1'b0;
        for (int r = 0; r < 11; r++) m_rk[r] = '0;

        tbl[0] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 0, 1'b0, 1'b1};
        for (int i = 1; i < 13; i++) tbl[i] = '{128'h0, 128'h0, i % 11, (i == 10), 1'b0};
        tbl[1].exp  = 128'ha0fafe1788542cb123a339392a6c7605; tbl[1].chk  = 1'b1;
        tbl[10].exp = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6; tbl[10].chk = 1'b1;
        tbl[11].exp = FKEY;                                  tbl[11].chk = 1'b1;
        tbl[12].exp = 128'ha0fafe1788542cb123a339392a6c7605; tbl[12].chk = 1'b1;

        // Reset, then in_valid pulses without a key must be ignored.
        step(1, 0, '0, 1, rnd128(), 1);
        step(1, 0, '0, 1, rnd128(), 1);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1, rnd128(), 1);
        check("reset_out_state", out_state, '0);

        // FIPS-197 vector and key-schedule sweep, back-to-back.
        step(0, 1, FKEY, 0, '0, 1);
        for (int i = 0; i < 13; i++) begin
            step(0, 0, '0, 1, tbl[i].st, 1);
            if (tbl[i].chk) begin
                check("tbl_state", out_state, tbl[i].exp);
                check("tbl_round", {124'b0, out_round}, {124'b0, 4'(tbl[i].rnd)});
                check("tbl_last", {127'b0, out_last}, {127'b0, tbl[i].last});
            end
        end

        // Backpressure: three stalled cycles with in_valid held high.
        step(1, 0, '0, 0, '0, 1);
        step(0, 1, rnd128(), 0, '0, 1);
        for (int i = 0; i < 10; i++) step(0, 0, '0, 1, rnd128(), !(i >= 2 && i < 5));

        // key_load during RUN is ignored; accepted after the last round.
        ka = rnd128(); kb = rnd128();
        step(1, 0, '0, 0, '0, 1);
        step(0, 1, ka, 0, '0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, '0, 1, '0, 1);
        step(0, 1, kb, 1, '0, 1);
        for (int i = 0; i < 6; i++) step(0, 0, '0, 1, '0, 1);
        check("run_last", {127'b0, out_last}, 128'd1);
        step(0, 1, kb, 0, '0, 1);
        st = rnd128();
        step(0, 0, '0, 1, st, 1);
        check("newkey_r0", out_state, st ^ kb);

        // Simultaneous key_load and in_valid in IDLE.
        kc = rnd128(); st = rnd128();
        for (int i = 0; i < 10; i++) step(0, 0, '0, 1, '0, 1);
        step(0, 1, kc, 1, st, 1);
        step(0, 0, '0, 1, st, 1);
        check("kl_and_valid", out_state, st ^ kc);

        // Reset mid-block with an output pending.
        step(0, 0, '0, 1, rnd128(), 1);
        step(0, 0, '0, 1, rnd128(), 0);
        step(1, 0, '0, 1, rnd128(), 0);
        check("midreset_valid", {127'b0, out_valid}, 128'd0);
        step(0, 0, '0, 1, rnd128(), 1);

        // Randomized traffic.
        step(0, 1, rnd128(), 0, '0, 1);
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0), rnd128(),
                 ($urandom_range(0, 3) != 0), rnd128(), ($urandom_range(0, 3) != 0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
